fault_inj_ctrl: RTL

FAULT_INJ_CTRL -- requirements
Module: fault_inj_ctrl

---
 rtl/fi_pkg.sv | 26 ++
 rtl/fi_lfsr.sv | 34 +++
 rtl/fault_inj_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fi_pkg.sv
// fi_pkg: shared types and constants for the fault injection controller.
// Holds the FSM state encoding, the LFSR feedback polynomial and the
// lookup table that maps a 3-bit draw field onto a target register index.
package fi_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DELAY  = 3'd1,
        INJECT = 3'd2,
        RUN    = 3'd3,
        REPORT = 3'd4
    } fi_state_e;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // Entry [n] is the register targeted when draw[27:25] == n.
    localparam logic [7:0][4:0] REG_LUT = {
        5'd9,  5'd23, 5'd22, 5'd21,
        5'd20, 5'd19, 5'd18, 5'd9
    };

    function automatic logic [4:0] reg_index(input logic [2:0] sel);
        return REG_LUT[sel];
    endfunction

endpackage

// File: rtl/fi_lfsr.sv
// fi_lfsr: 32-bit Galois LFSR, right-shifting, one step per clock.
// The low OUT_W bits of the state are exported; the full state is kept
// internally so the feedback sequence is unaffected by the output width.
module fi_lfsr
    import fi_pkg::*;
#(
    parameter logic [31:0] SEED  = 32'hACE1_2024,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic [OUT_W-1:0] lfsr_out
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    // Shift right and fold the polynomial back in when a one falls out.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);
    end

    // State register; reset reloads the seed so sequences are repeatable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_out = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/fault_inj_ctrl.sv
// fault_inj_ctrl: decides per protected run whether to inject a single-bit
// fault, waits a random delay, strobes the target and reports the outcome.
// Build option: define FI_WATCHDOG_EN to add the run-length watchdog that
// ends a run after TIMEOUT cycles; without it a run ends only on run_done.
module fault_inj_ctrl
    import fi_pkg::*;
#(
    parameter int unsigned FAULT_THR  = 179,
    parameter int unsigned DELAY_BASE = 900,
    parameter logic [11:0] DELAY_MASK = 12'hFFF,
    parameter logic [31:0] TIMEOUT    = 32'h0000_C000,
    parameter logic [31:0] SEED       = 32'hACE1_2024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_start,
    input  logic        run_done,
    output logic        fault_req,
    output logic [4:0]  fault_reg,
    output logic [4:0]  fault_bit,
    output logic        res_valid,
    output logic        res_injected,
    output logic        res_timeout,
    output logic [15:0] exp_count
);

    logic [27:0] lfsr_val;

    fi_state_e   state_q, state_d;
    logic [27:0] draw_q, draw_d;
    logic [31:0] count_q, count_d;
    logic        run_start_q, run_start_d;
    logic        fault_req_q, fault_req_d;
    logic [4:0]  fault_reg_q, fault_reg_d;
    logic [4:0]  fault_bit_q, fault_bit_d;
    logic        res_valid_q, res_valid_d;
    logic        res_injected_q, res_injected_d;
    logic        res_timeout_q, res_timeout_d;
    logic [15:0] exp_count_q, exp_count_d;
    logic        timeout_hit;

`ifdef FI_WATCHDOG_EN
    logic [31:0] wdog_q, wdog_d;
`else
    logic        unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    fi_lfsr #(
        .SEED  (SEED),
        .OUT_W (28)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .lfsr_out (lfsr_val)
    );

    // Next-state, next-output and counter logic for the whole controller.
    always_comb begin
        state_d        = state_q;
        draw_d         = draw_q;
        count_d        = count_q;
        run_start_d    = run_start;
        fault_req_d    = 1'b0;
        fault_reg_d    = fault_reg_q;
        fault_bit_d    = fault_bit_q;
        res_valid_d    = 1'b0;
        res_injected_d = res_injected_q;
        res_timeout_d  = res_timeout_q;
        exp_count_d    = exp_count_q;

`ifdef FI_WATCHDOG_EN
        // The count includes the current cycle, so it reaches TIMEOUT on the
        // TIMEOUT-th cycle after leaving IDLE.
        if (state_q == IDLE) begin
            wdog_d = 32'd0;
        end else if (wdog_q == TIMEOUT) begin
            wdog_d = wdog_q;
        end else begin
            wdog_d = wdog_q + 32'd1;
        end
        timeout_hit = (wdog_d == TIMEOUT);
`else
        timeout_hit = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (run_start && !run_start_q) begin
                    draw_d         = lfsr_val;
                    res_injected_d = 1'b0;
                    res_timeout_d  = 1'b0;
                    if ({24'd0, lfsr_val[7:0]} < FAULT_THR) begin
                        state_d = DELAY;
                        count_d = DELAY_BASE + {20'd0, lfsr_val[19:8] & DELAY_MASK};
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            DELAY: begin
                if (run_done) begin
                    state_d     = REPORT;
                    res_valid_d = 1'b1;
                    exp_count_d = exp_count_q + 16'd1;
                end else if (count_q == 32'd0) begin
                    state_d        = INJECT;
                    fault_req_d    = 1'b1;
                    fault_bit_d    = draw_q[24:20];
                    fault_reg_d    = reg_index(draw_q[27:25]);
                    res_injected_d = 1'b1;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            INJECT: begin
                state_d = RUN;
            end
            RUN: begin
                if (run_done) begin
                    state_d     = REPORT;
                    res_valid_d = 1'b1;
                    exp_count_d = exp_count_q + 16'd1;
                end else if (timeout_hit) begin
                    state_d       = REPORT;
                    res_valid_d   = 1'b1;
                    res_timeout_d = 1'b1;
                    exp_count_d   = exp_count_q + 16'd1;
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Single register stage for state, counters and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            draw_q         <= '0;
            count_q        <= '0;
            run_start_q    <= 1'b0;
            fault_req_q    <= 1'b0;
            fault_reg_q    <= '0;
            fault_bit_q    <= '0;
            res_valid_q    <= 1'b0;
            res_injected_q <= 1'b0;
            res_timeout_q  <= 1'b0;
            exp_count_q    <= '0;
`ifdef FI_WATCHDOG_EN
            wdog_q         <= '0;
`endif
        end else begin
            state_q        <= state_d;
            draw_q         <= draw_d;
            count_q        <= count_d;
            run_start_q    <= run_start_d;
            fault_req_q    <= fault_req_d;
            fault_reg_q    <= fault_reg_d;
            fault_bit_q    <= fault_bit_d;
            res_valid_q    <= res_valid_d;
            res_injected_q <= res_injected_d;
            res_timeout_q  <= res_timeout_d;
            exp_count_q    <= exp_count_d;
`ifdef FI_WATCHDOG_EN
            wdog_q         <= wdog_d;
`endif
        end
    end

    assign fault_req    = fault_req_q;
    assign fault_reg    = fault_reg_q;
    assign fault_bit    = fault_bit_q;
    assign res_valid    = res_valid_q;
    assign res_injected = res_injected_q;
    assign res_timeout  = res_timeout_q;
    assign exp_count    = exp_count_q;

endmodule
